// File: rtl/usr_pkg.sv
// Shared definitions for the USR command sequencer: opcodes (identical to the
// USR {S1,S0} mode encoding) and the sequencer state encoding.
package usr_pkg;

    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_SHR  = 2'b01;
    localparam logic [1:0] OP_SHL  = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/usr_cmd_sequencer_if.sv
// Command/response bundle between the two requesters and the sequencer.
// Per-requester fields are packed arrays indexed by requester id.
interface usr_cmd_sequencer_if #(
    parameter int CNT_W = 4
) ();

    logic [1:0]            req_valid;
    logic [1:0]            req_ready;
    logic [1:0][1:0]       req_op;
    logic [1:0][3:0]       req_data;
    logic [1:0]            req_fill;
    logic [1:0][CNT_W-1:0] req_cnt;
    logic                  rsp_valid;
    logic                  rsp_id;
    logic [3:0]            rsp_q;

    modport master (
        output req_valid, req_op, req_data, req_fill, req_cnt,
        input  req_ready, rsp_valid, rsp_id, rsp_q
    );

    modport slave (
        input  req_valid, req_op, req_data, req_fill, req_cnt,
        output req_ready, rsp_valid, rsp_id, rsp_q
    );

endinterface

// File: rtl/usr_cmd_sequencer_rr_arb2.sv
// Two-input round-robin arbiter; last_q remembers the most recent winner and
// resets to 1 so requester 0 takes the first tie.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    input  logic       advance,
    output logic [1:0] grant
);

    logic last_q;
    logic last_d;

    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // Priority only rotates once a grant is actually taken.
    always_comb begin
        last_d = last_q;
        if (advance) begin
            last_d = grant[1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/usr_cmd_sequencer.sv
// Sequences commands from two requesters onto a 4-bit universal shift register
// and returns the register contents to the requester once the command finishes.
module usr_cmd_sequencer
    import usr_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    usr_cmd_sequencer_if.slave   cmd,
    output logic                 usr_ena,
    output logic [1:0]           usr_s,
    output logic                 usr_sl,
    output logic                 usr_sr,
    output logic [3:0]           usr_d,
    input  logic [3:0]           usr_q,
    output logic                 busy
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic [3:0]       data_q, data_d;
    logic             fill_q, fill_d;
    logic             id_q, id_d;

    logic [1:0]       grant;
    logic             take;
    logic             sel;
    logic             in_run;
    logic             in_done;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid   (cmd.req_valid),
        .advance (take),
        .grant   (grant)
    );

    // Gating with rst_n keeps a handshake from being seen during a reset cycle.
    assign cmd.req_ready = (state_q == ST_IDLE && rst_n) ? grant : 2'b00;
    assign take          = |(cmd.req_valid & cmd.req_ready);
    assign sel           = grant[1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        data_d  = data_q;
        fill_d  = fill_q;
        id_d    = id_q;
        case (state_q)
            ST_IDLE: begin
                if (take) begin
                    op_d   = cmd.req_op[sel];
                    data_d = cmd.req_data[sel];
                    fill_d = cmd.req_fill[sel];
                    id_d   = sel;
                    cnt_d  = (cmd.req_op[sel] == OP_LOAD) ? CNT_W'(1) : cmd.req_cnt[sel];
                    state_d = (cnt_d != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_HOLD;
            data_q  <= 4'b0000;
            fill_q  <= 1'b0;
            id_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            data_q  <= data_d;
            fill_q  <= fill_d;
            id_q    <= id_d;
        end
    end

    assign in_run  = (state_q == ST_RUN);
    assign in_done = (state_q == ST_DONE);

    // The latched opcode is already the USR mode encoding, so it passes straight through.
    assign usr_ena = in_run;
    assign usr_s   = in_run ? op_q : OP_HOLD;
    assign usr_sr  = in_run && (op_q == OP_SHR) && fill_q;
    assign usr_sl  = in_run && (op_q == OP_SHL) && fill_q;
    assign usr_d   = (in_run && op_q == OP_LOAD) ? data_q : 4'b0000;

    assign cmd.rsp_valid = in_done;
    assign cmd.rsp_id    = in_done & id_q;
    assign cmd.rsp_q     = in_done ? usr_q : 4'b0000;
    assign busy          = (state_q != ST_IDLE);

endmodule

// File: doc/usr_cmd_sequencer.md
# usr_cmd_sequencer

Two-requester command sequencer for the 4-bit universal shift register (USR). It arbitrates round-robin between two command ports and drives the USR mode, serial and parallel inputs for the required number of clock cycles. On completion it returns the final register contents to the granted requester. It sits directly in front of the USR; the USR's `ena`, `{S1,S0}`, `SL`, `SR` and `D` come only from this block.

## Interface
- `CNT_W`, default 4: width of the shift-count field. Maximum count is 2^CNT_W−1.
- `clk`  in  1  clock
- `rst_n`  in  1  reset, synchronous, active-low
- `req_valid`  in  2  command valid, one bit per requester
- `req_ready`  out  2  command accepted; a command transfers when `req_valid[i] & req_ready[i]`
- `req_op`  in  2×2  per-requester opcode: 00 HOLD, 01 SHR, 10 SHL, 11 LOAD
- `req_data`  in  2×4  per-requester parallel data, used by LOAD
- `req_fill`  in  2×1  per-requester serial bit: drives SR on SHR, SL on SHL
- `req_cnt`  in  2×CNT_W  per-requester step count, used by SHR/SHL/HOLD
- `usr_ena`  out  1  USR enable
- `usr_s`  out  2  USR mode `{S1,S0}`
- `usr_sl`, `usr_sr`  out  1 each  USR serial-left / serial-right inputs
- `usr_d`  out  4  USR parallel data
- `usr_q`  in  4  USR register state
- `rsp_valid`  out  1  one-cycle completion pulse
- `rsp_id`  out  1  requester index of the completed command
- `rsp_q`  out  4  `usr_q` sampled at completion
- `busy`  out  1  high when not IDLE

## Operation
- States:
  - **IDLE**: waiting for a command.
  - **RUN**: driving the USR for a set number of cycles.
  - **DONE**: reporting the result.
- **IDLE**
  - `req_ready` is one-hot to the round-robin winner among the asserted `req_valid` bits. It is 0 when no request is pending.
  - On the handshake, latch op, data, fill and id. Set the step counter:
    - LOAD: 1.
    - SHR, SHL, HOLD: `req_cnt`.
  - Go to RUN if the counter is nonzero, otherwise go to DONE.
- **Round-robin**
  - `last` holds the index of the last granted requester and resets to 1, so requester 0 wins the first tie.
  - When both requesters are valid, grant `~last`. When only one is valid, grant that one.
  - Update `last` only on a handshake.
- **RUN**
  - Drive `usr_ena`=1 and `usr_s`=the latched op.
  - SHR: drive `usr_sr`=fill. SHL: drive `usr_sl`=fill. LOAD: drive `usr_d`=data.
  - Decrement the counter each cycle. Go to DONE in the cycle the counter reaches 1.
- **DONE**
  - Drive `rsp_valid`=1, `rsp_id`=the latched id and `rsp_q`=`usr_q`.
  - `usr_q` already reflects the last step at this point.
  - Return to IDLE.
- **Outside RUN**: `usr_ena`=0, `usr_s`=00, and `usr_sl`, `usr_sr`, `usr_d` are all 0.
- `rsp_valid` has no backpressure. A requester must be ready to take the response.
- A requester that drops `req_valid` before its handshake loses nothing; no state is held for it.
- Request inputs are ignored outside IDLE.

## Timing
- Handshake in cycle T. N is the step count: 1 for LOAD, `req_cnt` otherwise.
- For N≥1:
  - `usr_ena` is high in cycles T+1 … T+N.
  - USR Q updates at the end of each of those cycles.
  - `rsp_valid` is high in cycle T+N+1.
  - The next handshake is possible at T+N+2.
- For N=0: `rsp_valid` is high in cycle T+1 and `usr_ena` is never asserted.
- Reset, in any state including mid-RUN: the next cycle is IDLE, counter=0 and `last`=1. All outputs are 0, including `req_ready`, `rsp_valid`, `busy` and all `usr_*` outputs.
- The USR shares `rst_n`, so Q is also 0 after reset.

## Structure
- Shared package `usr_pkg` holds:
  - the opcode constants `OP_HOLD`=2'b00, `OP_SHR`=2'b01, `OP_SHL`=2'b10, `OP_LOAD`=2'b11; these equal the USR `{S1,S0}` encoding and are passed through unchanged;
  - the state encoding IDLE/RUN/DONE.
- Sub-module `rr_arb2` contains the two-input round-robin arbiter and its `last` register. It has inputs valid[1:0] and advance, and output grant[1:0] (one-hot).
- The FSM, counter and command latches live in `usr_cmd_sequencer`.

## Test plan
- Reset, then requester 0 sends LOAD with data=4'b1010 → `usr_ena` high for exactly 1 cycle with `usr_s`=11. `rsp_valid` pulses 2 cycles after the handshake with `rsp_id`=0 and `rsp_q`=1010.
- After Q=1010, requester 1 sends SHR with cnt=3 and fill=1 → 3 enable cycles with `usr_s`=01 and `usr_sr`=1. Response has `rsp_id`=1 and `rsp_q`=1111.
- After Q=1010, SHL with cnt=2 and fill=0 → `rsp_q`=1000. HOLD with cnt=2 → `rsp_q` unchanged and `usr_s`=00 during RUN.
- SHR with cnt=0 → `rsp_valid` at T+1, no `usr_ena` pulse, `rsp_q` equals the prior Q.
- Both requesters hold `req_valid` continuously with LOADs of 0x1 (req0) and 0x2 (req1) → grants alternate 0,1,0,1 and `rsp_q` alternates 0001/0010. No grant is given while `busy`.
- Assert `rst_n`=0 in the second cycle of a cnt=5 SHR → the next cycle is IDLE, all outputs are 0 and no `rsp_valid` is issued. A following tie is granted to requester 0.
